mem_arbiter: RTL and testbench

//  Shares the CPU's single-port program/data memory between three requesters:

---
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_arbiter
// Brief  : Serialises loader, data and fetch accesses onto one memory port.
// Rev    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic              CLK_50,
  input  logic              KEY0,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int c_CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
  // The memory samples its address on the edge that ends ACCESS, and the data
  // is valid MEM_LAT clocks after that edge, so WAIT spans MEM_LAT+1 cycles.
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(MEM_LAT);

  localparam logic [1:0] c_GNT_LD = 2'd0;
  localparam logic [1:0] c_GNT_D  = 2'd1;
  localparam logic [1:0] c_GNT_F  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [1:0]         r_grant;
  logic [1:0]         w_grant;
  logic               w_start;
  logic               r_rr;       // 0: D preferred on a D/F tie, 1: F preferred
  logic               r_we;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = r_grant;
    w_start     = 1'b0;
    busy        = (r_state != ST_IDLE);
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    ld_ack      = 1'b0;
    d_ack       = 1'b0;
    f_ack       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (ld_req) begin
          w_start = 1'b1;
          w_grant = c_GNT_LD;
        end else if (d_req && (!f_req || !r_rr)) begin
          w_start = 1'b1;
          w_grant = c_GNT_D;
        end else if (f_req) begin
          w_start = 1'b1;
          w_grant = c_GNT_F;
        end
        if (w_start) begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_en      = 1'b1;
        mem_we      = r_we;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        ld_ack      = (r_grant == c_GNT_LD);
        d_ack       = (r_grant == c_GNT_D);
        f_ack       = (r_grant == c_GNT_F);
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_50 or negedge KEY0) begin
    if (!KEY0) begin
      r_grant   <= c_GNT_LD;
      r_rr      <= 1'b0;
      r_we      <= 1'b0;
      r_cnt     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_grant <= w_grant;
            if (w_grant == c_GNT_LD) begin
              mem_addr  <= ld_addr;
              mem_wdata <= ld_wdata;
              r_we      <= ld_we;
            end else if (w_grant == c_GNT_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              r_we      <= d_we;
              r_rr      <= 1'b1;
            end else begin
              mem_addr  <= f_addr;
              r_we      <= 1'b0;
              r_rr      <= 1'b0;
            end
          end
        end
        ST_ACCESS: r_cnt <= c_CNT_LOAD;
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end else if (!r_we) begin
            rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// Directed bench for mem_arbiter: one MEM_LAT=1 instance with a small RAM
// model and one MEM_LAT=3 instance with an address-derived read pipeline.
module tb_mem_arbiter;

  localparam int P_NONE = 0;
  localparam int P_LD   = 1;
  localparam int P_D    = 2;
  localparam int P_F    = 3;
  localparam int P_MULTI = 4;

  logic        CLK_50 = 1'b0;
  logic        KEY0   = 1'b0;
  always #5 CLK_50 = ~CLK_50;

  logic        ld_req, ld_we, d_req, d_we, f_req;
  logic [15:0] ld_addr, ld_wdata, d_addr, d_wdata, f_addr;
  logic        ld_ack, d_ack, f_ack, busy, mem_en, mem_we;
  logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;

  logic        d2_req;
  logic [15:0] d2_addr;
  logic        u2_ld_ack, u2_d_ack, u2_f_ack, u2_busy, mem2_en, mem2_we;
  logic [15:0] u2_rdata, mem2_addr, mem2_wdata, mem2_rdata;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut (
    .CLK_50(CLK_50), .KEY0(KEY0),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack),
    .rdata(rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u_dut3 (
    .CLK_50(CLK_50), .KEY0(KEY0),
    .ld_req(1'b0), .ld_we(1'b0), .ld_addr(16'h0), .ld_wdata(16'h0), .ld_ack(u2_ld_ack),
    .d_req(d2_req), .d_we(1'b0), .d_addr(d2_addr), .d_wdata(16'h0), .d_ack(u2_d_ack),
    .f_req(1'b0), .f_addr(16'h0), .f_ack(u2_f_ack),
    .rdata(u2_rdata), .busy(u2_busy),
    .mem_en(mem2_en), .mem_we(mem2_we), .mem_addr(mem2_addr), .mem_wdata(mem2_wdata),
    .mem_rdata(mem2_rdata)
  );

  // RAM model for the MEM_LAT=1 instance, with a preload port for the bench
  logic [15:0] mem [0:63];
  logic [15:0] mem_q;
  logic        pl_we;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;
  always @(posedge CLK_50) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[5:0]] <= mem_wdata;
    if (mem_en) mem_q <= mem[mem_addr[5:0]];
  end
  assign mem_rdata = mem_q;

  // Three-stage read pipeline returning addr ^ 'hA5A5
  logic [15:0] p0, p1, p2;
  always @(posedge CLK_50) begin
    if (mem2_en) p0 <= mem2_addr ^ 16'hA5A5;
    p1 <= p0;
    p2 <= p1;
  end
  assign mem2_rdata = p2;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_50);
    #1;
  endtask

  // Advances until an ack appears or max edges elapse; cycles counts edges.
  task automatic wait_ack(input int max, output int port, output int cycles, output int busy_low);
    int s;
    port = P_NONE; cycles = 0; busy_low = 0;
    while (port == P_NONE && cycles < max) begin
      tick();
      cycles++;
      if (!busy) busy_low++;
      s = int'(ld_ack) + int'(d_ack) + int'(f_ack);
      if (s > 1)       port = P_MULTI;
      else if (ld_ack) port = P_LD;
      else if (d_ack)  port = P_D;
      else if (f_ack)  port = P_F;
    end
  endtask

  initial begin
    int port, cyc, bl, en_cnt;
    ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    f_req = 0; f_addr = 0; d2_req = 0; d2_addr = 0;
    pl_we = 0; pl_addr = 0; pl_data = 0;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_acks", {ld_ack, d_ack, f_ack}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst3_busy", u2_busy, 0);
    chk("rst3_rdata", u2_rdata, 0);
    chk("rst3_mem_wdata", mem2_wdata, 0);

    pl_we = 1; pl_addr = 6'd5; pl_data = 16'h6001;
    tick();
    pl_we = 0;
    KEY0 = 1;
    tick();

    // 1: reset asserted while a write sits in ACCESS
    d_req = 1; d_we = 1; d_addr = 16'd40; d_wdata = 16'h1234;
    tick();
    chk("t1_access_en", mem_en, 1);
    chk("t1_access_we", mem_we, 1);
    chk("t1_access_addr", mem_addr, 16'd40);
    #2 KEY0 = 0;
    #1;
    chk("t1_rst_en", mem_en, 0);
    chk("t1_rst_we", mem_we, 0);
    chk("t1_rst_busy", busy, 0);
    d_req = 0; d_we = 0;
    tick(); tick();
    KEY0 = 1;
    wait_ack(8, port, cyc, bl);
    chk("t1_no_ack", port, P_NONE);

    // 2: fetch read of preloaded word
    f_req = 1; f_addr = 16'd5;
    wait_ack(20, port, cyc, bl);
    chk("t2_port", port, P_F);
    chk("t2_latency", cyc, 4);
    chk("t2_rdata", rdata, 16'h6001);
    f_req = 0;
    tick();

    // 3: data write then fetch read-back
    d_req = 1; d_we = 1; d_addr = 16'd31; d_wdata = 16'h6002;
    tick();
    chk("t3_en", mem_en, 1);
    chk("t3_we", mem_we, 1);
    chk("t3_addr", mem_addr, 16'd31);
    chk("t3_wdata", mem_wdata, 16'h6002);
    wait_ack(20, port, cyc, bl);
    chk("t3_wr_port", port, P_D);
    chk("t3_wr_latency", cyc, 3);
    chk("t3_wr_rdata_hold", rdata, 16'h6001);
    d_req = 0; d_we = 0;
    tick();
    f_req = 1; f_addr = 16'd31;
    wait_ack(20, port, cyc, bl);
    chk("t3_rd_port", port, P_F);
    chk("t3_rd_latency", cyc, 4);
    chk("t3_rd_rdata", rdata, 16'h6002);
    f_req = 0;
    tick();

    // 4: D and F held together alternate
    d_req = 1; d_addr = 16'd5; f_req = 1; f_addr = 16'd31;
    for (int i = 0; i < 6; i++) begin
      wait_ack(20, port, cyc, bl);
      chk($sformatf("t4_port%0d", i), port, (i % 2 == 0) ? P_D : P_F);
      chk($sformatf("t4_rdata%0d", i), rdata, (i % 2 == 0) ? 16'h6001 : 16'h6002);
      if (i > 0) chk($sformatf("t4_busy_low%0d", i), bl, 1);
    end
    d_req = 0; f_req = 0;
    tick();

    // 5: loader outranks D and F; its grants leave the pointer alone
    ld_req = 1; ld_we = 0; ld_addr = 16'd5;
    d_req = 1; f_req = 1;
    for (int i = 0; i < 4; i++) begin
      wait_ack(20, port, cyc, bl);
      chk($sformatf("t5_ld%0d", i), port, P_LD);
      chk($sformatf("t5_ld_rdata%0d", i), rdata, 16'h6001);
    end
    ld_req = 0;
    wait_ack(20, port, cyc, bl);
    chk("t5_after_d", port, P_D);
    wait_ack(20, port, cyc, bl);
    chk("t5_after_f", port, P_F);
    ld_req = 1;
    wait_ack(20, port, cyc, bl);
    chk("t5_single_ld", port, P_LD);
    ld_req = 0;
    wait_ack(20, port, cyc, bl);
    chk("t5_single_after_d", port, P_D);
    d_req = 0; f_req = 0;
    tick();

    // 6: MEM_LAT=3 instance, single data read
    d2_req = 1; d2_addr = 16'd7;
    cyc = 0; en_cnt = 0;
    while (!u2_d_ack && cyc < 20) begin
      tick();
      cyc++;
      if (mem2_en) en_cnt++;
      if (mem2_we) en_cnt += 100;
    end
    chk("t6_ack", u2_d_ack, 1);
    chk("t6_other_acks", {u2_ld_ack, u2_f_ack}, 0);
    chk("t6_latency", cyc, 6);
    chk("t6_en_cycles", en_cnt, 1);
    chk("t6_rdata", u2_rdata, 16'hA5A2);
    d2_req = 0;
    tick();
    chk("t6_ack_pulse", u2_d_ack, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
